// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP controller states, host sizing and the IR opcodes
// understood by the target.
package jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_ctrl_fsm_t;

  localparam int unsigned JTAG_HOST_MAX_LEN = 64;

  localparam int unsigned            JTAG_IR_W      = 5;
  localparam logic [JTAG_IR_W-1:0]   JTAG_IR_IDCODE = 5'b00001;
  localparam logic [JTAG_IR_W-1:0]   JTAG_IR_BYPASS = 5'b11111;

endpackage

// File: rtl/jtag_tap_model.sv
// Combinational IEEE 1149.1 TAP controller next-state function, shared by host and target.
module jtag_tap_model
  import jtag_pkg::*;
(
  input  tap_ctrl_fsm_t state,
  input  logic          tms,
  output tap_ctrl_fsm_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      TestLogicReset: next_state = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    next_state = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   next_state = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      next_state = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        next_state = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        next_state = tms ? UpdateDr       : PauseDr;
      PauseDr:        next_state = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        next_state = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       next_state = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   next_state = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      next_state = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        next_state = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        next_state = tms ? UpdateIr       : PauseIr;
      PauseIr:        next_state = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        next_state = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       next_state = tms ? SelectDrScan   : RunTestIdle;
      default:        next_state = TestLogicReset;
    endcase
  end

endmodule

// File: rtl/jtag_host.sv
// JTAG scan host: runs the TAP reset sequence, then executes one IR or DR scan per command
// and returns the captured TDO bits. Control state moves on rising tck, TAP pins on falling.
module jtag_host
  import jtag_pkg::*;
#(
  parameter int unsigned MAX_LEN     = JTAG_HOST_MAX_LEN,
  parameter int unsigned LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned RST_TMS_CNT = 5
) (
  input  logic               tck,
  input  logic               trstn,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_ir_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               busy_o
);

  localparam int unsigned        RstCntW = $clog2(RST_TMS_CNT + 2);
  localparam logic [RstCntW-1:0] RstDone = RstCntW'(RST_TMS_CNT + 1);
  localparam logic [LEN_W-1:0]   LenMax  = LEN_W'(MAX_LEN);

  tap_ctrl_fsm_t      tap_q, tap_next;
  logic [RstCntW-1:0] rst_cnt_q;
  logic               active_q, zero_q, busy_q, rsp_valid_q, rsp_err_q, ir_q;
  logic [LEN_W-1:0]   len_q, cnt_q, len_sat;
  logic [MAX_LEN-1:0] data_q, rsp_data_q;
  logic               tms_q, tdi_q, tms_d, tdi_d;
  logic               rst_done, in_shift, accept, done, active_d, zero_d, busy_d;

  jtag_tap_model u_tap_model (
    .state      (tap_q),
    .tms        (tms_q),
    .next_state (tap_next)
  );

  assign rst_done    = (rst_cnt_q == RstDone);
  assign in_shift    = (tap_q == ShiftDr) || (tap_q == ShiftIr);
  assign cmd_ready_o = (tap_q == RunTestIdle) && !rsp_valid_q && !busy_q;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign len_sat     = (cmd_len_i > LenMax) ? LenMax : cmd_len_i;
  // The Update state always leaves with TMS=0, so it is the last edge of a scan.
  assign done        = active_q && ((tap_q == UpdateDr) || (tap_q == UpdateIr));
  assign zero_d      = accept && (len_sat == '0);
  assign active_d    = (accept && (len_sat != '0)) || (active_q && !done);
  assign busy_d      = !((tap_q == RunTestIdle) && rst_done && !active_d && !zero_d);

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      tap_q       <= TestLogicReset;
      rst_cnt_q   <= '0;
      active_q    <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b1;
      ir_q        <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      tap_q    <= tap_next;
      active_q <= active_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      if (!rst_done) begin
        rst_cnt_q <= rst_cnt_q + RstCntW'(1);
      end
      if (accept) begin
        ir_q       <= cmd_ir_i;
        len_q      <= len_sat;
        data_q     <= cmd_data_i;
        cnt_q      <= '0;
        rsp_data_q <= '0;
        rsp_err_q  <= (len_sat == '0);
      end else if (active_q && in_shift) begin
        rsp_data_q <= rsp_data_q | (MAX_LEN'(tdo_i) << cnt_q);
        data_q     <= data_q >> 1;
        cnt_q      <= cnt_q + LEN_W'(1);
      end
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end else if (done || zero_q) begin
        rsp_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    if (!rst_done) begin
      tms_d = (rst_cnt_q < RstCntW'(RST_TMS_CNT));
    end else if (active_q) begin
      case (tap_q)
        RunTestIdle:      tms_d = 1'b1;
        SelectDrScan:     tms_d = ir_q;
        ShiftDr, ShiftIr: begin
          tms_d = (cnt_q == len_q - LEN_W'(1));
          tdi_d = data_q[0];
        end
        Exit1Dr, Exit1Ir: tms_d = 1'b1;
        default:          tms_d = 1'b0;
      endcase
    end
  end

  // Pins launched on the falling edge stay stable across the target's rising-edge sample.
  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end

  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a behavioural TAP target with IDCODE/BYPASS registers, a command
// driver that queues expected responses, and a monitor that checks each response.
module tb_jtag_host;
  import jtag_pkg::*;

  localparam int unsigned MaxLen    = 64;
  localparam int unsigned LenW      = 7;
  localparam logic [31:0] IdcodeVal = 32'hBADC0FFE;

  logic              tck = 1'b0;
  logic              trstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_ir = 1'b0;
  logic [LenW-1:0]   cmd_len = '0;
  logic [MaxLen-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [MaxLen-1:0] rsp_data;
  logic              rsp_err;
  logic              tms, tdi, tdo, busy;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_no = 0;

  jtag_host #(
    .MAX_LEN     (MaxLen),
    .LEN_W       (LenW),
    .RST_TMS_CNT (5)
  ) dut (
    .tck         (tck),
    .trstn       (trstn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_ir_i    (cmd_ir),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo),
    .busy_o      (busy)
  );

  always #5 tck = ~tck;
  always @(posedge tck) edge_no <= edge_no + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // ---------------- target TAP ----------------
  function automatic tap_ctrl_fsm_t tap_step(input tap_ctrl_fsm_t s, input logic m);
    case (s)
      TestLogicReset: return m ? TestLogicReset : RunTestIdle;
      RunTestIdle:    return m ? SelectDrScan : RunTestIdle;
      SelectDrScan:   return m ? SelectIrScan : CaptureDr;
      CaptureDr:      return m ? Exit1Dr : ShiftDr;
      ShiftDr:        return m ? Exit1Dr : ShiftDr;
      Exit1Dr:        return m ? UpdateDr : PauseDr;
      PauseDr:        return m ? Exit2Dr : PauseDr;
      Exit2Dr:        return m ? UpdateDr : ShiftDr;
      UpdateDr:       return m ? SelectDrScan : RunTestIdle;
      SelectIrScan:   return m ? TestLogicReset : CaptureIr;
      CaptureIr:      return m ? Exit1Ir : ShiftIr;
      ShiftIr:        return m ? Exit1Ir : ShiftIr;
      Exit1Ir:        return m ? UpdateIr : PauseIr;
      PauseIr:        return m ? Exit2Ir : PauseIr;
      Exit2Ir:        return m ? UpdateIr : ShiftIr;
      default:        return m ? SelectDrScan : RunTestIdle;
    endcase
  endfunction

  tap_ctrl_fsm_t        t_state;
  logic [JTAG_IR_W-1:0] ir_sr, ir_reg;
  logic [31:0]          dr_sr;
  logic                 byp;

  always @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      t_state <= TestLogicReset;
      ir_reg  <= JTAG_IR_IDCODE;
      ir_sr   <= '0;
      dr_sr   <= '0;
      byp     <= 1'b0;
    end else begin
      t_state <= tap_step(t_state, tms);
      case (t_state)
        TestLogicReset: ir_reg <= JTAG_IR_IDCODE;
        CaptureIr:      ir_sr <= 5'b00001;
        ShiftIr:        ir_sr <= {tdi, ir_sr[JTAG_IR_W-1:1]};
        UpdateIr:       ir_reg <= ir_sr;
        CaptureDr: begin
          dr_sr <= IdcodeVal;
          byp   <= 1'b0;
        end
        ShiftDr: begin
          dr_sr <= {tdi, dr_sr[31:1]};
          byp   <= tdi;
        end
        default: ;
      endcase
    end
  end

  always @(negedge tck or negedge trstn) begin
    if (!trstn) tdo <= 1'b0;
    else if (t_state == ShiftIr) tdo <= ir_sr[0];
    else if (t_state == ShiftDr) tdo <= (ir_reg == JTAG_IR_IDCODE) ? dr_sr[0] : byp;
    else tdo <= 1'b0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic prev_valid = 1'b0;

  always begin
    @(posedge tck);
    #1;
    if (rsp_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h, want no response", rsp_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_data"}, rsp_data, e.data);
        chk1({e.name, "_err"}, rsp_err, e.err);
        chk({e.name, "_latency"}, 64'(edge_no - e.acc), 64'(e.lat));
      end
    end
    prev_valid = rsp_valid;
  end

  // ---------------- driver ----------------
  task automatic scan(input string name, input logic ir, input int len, input logic [63:0] data,
                      input bit expect_rsp, input logic [63:0] exp_data, input logic exp_err,
                      input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge tck);
    while (!cmd_ready && n < 200) begin
      @(negedge tck);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_ready_timeout: cmd_ready=0, want 1", name);
      return;
    end
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = LenW'(len);
    cmd_data  = data;
    @(posedge tck);
    #1;
    // Scramble the command inputs: the scan must run from the latched copy.
    cmd_valid = 1'b0;
    cmd_ir    = ~ir;
    cmd_len   = LenW'($urandom);
    cmd_data  = {$urandom, $urandom};
    if (expect_rsp) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.lat  = exp_lat;
      e.acc  = edge_no;
      e.name = name;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge tck);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%b, want a response", name, rsp_valid);
      sb_q.delete();
    end
  endtask

  task automatic reset_seq(input string name);
    @(negedge tck);
    #1 trstn = 1'b0;
    #2;
    chk1({name, "_rst_tms"}, tms, 1'b1);
    chk1({name, "_rst_tdi"}, tdi, 1'b0);
    chk1({name, "_rst_ready"}, cmd_ready, 1'b0);
    chk1({name, "_rst_rsp_valid"}, rsp_valid, 1'b0);
    chk({name, "_rst_rsp_data"}, rsp_data, 64'h0);
    chk1({name, "_rst_rsp_err"}, rsp_err, 1'b0);
    chk1({name, "_rst_busy"}, busy, 1'b1);
    #1 trstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge tck);
      #1;
      chk1($sformatf("%s_tms_e%0d", name, k), tms, k <= 5);
      chk1($sformatf("%s_ready_e%0d", name, k), cmd_ready, k == 7);
      chk1($sformatf("%s_busy_e%0d", name, k), busy, k != 7);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_seq("por");

    scan("ir_idcode", 1'b1, 5, 64'(JTAG_IR_IDCODE), 1'b1, 64'h1, 1'b0, 11);
    wait_rsp("ir_idcode");
    scan("dr_idcode", 1'b0, 32, 64'h0, 1'b1, 64'hBADC0FFE, 1'b0, 37);
    wait_rsp("dr_idcode");

    scan("ir_bypass", 1'b1, 5, 64'(JTAG_IR_BYPASS), 1'b1, 64'h1, 1'b0, 11);
    wait_rsp("ir_bypass");
    scan("dr_byp8", 1'b0, 8, 64'hA5, 1'b1, 64'h4A, 1'b0, 13);
    wait_rsp("dr_byp8");
    scan("dr_sat", 1'b0, 100, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0246_8ACF_1357_9BDE, 1'b0, 69);
    wait_rsp("dr_sat");

    scan("zero_len", 1'b0, 0, 64'hFFFF, 1'b1, 64'h0, 1'b1, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge tck);
      #1;
      chk1($sformatf("zero_len_tms_e%0d", k), tms, 1'b0);
    end
    wait_rsp("zero_len");

    rsp_ready = 1'b0;
    scan("hold", 1'b0, 8, 64'h3C, 1'b1, 64'h78, 1'b0, 13);
    wait_rsp("hold");
    for (int k = 0; k < 20; k++) begin
      @(posedge tck);
      #1;
      chk($sformatf("hold_data_c%0d", k), rsp_data, 64'h78);
      chk1($sformatf("hold_valid_c%0d", k), rsp_valid, 1'b1);
      chk1($sformatf("hold_ready_c%0d", k), cmd_ready, 1'b0);
      chk1($sformatf("hold_tms_c%0d", k), tms, 1'b0);
    end
    @(negedge tck);
    rsp_ready = 1'b1;

    scan("ir_len1", 1'b1, 1, 64'h0, 1'b1, 64'h1, 1'b0, 7);
    wait_rsp("ir_len1");

    // Abort a 32-bit scan on its 10th shift edge; no response may follow.
    scan("abort", 1'b0, 32, 64'hDEAD_BEEF, 1'b0, 64'h0, 1'b0, 0);
    repeat (13) @(posedge tck);
    reset_seq("rst2");

    scan("ir_idcode2", 1'b1, 5, 64'(JTAG_IR_IDCODE), 1'b1, 64'h1, 1'b0, 11);
    wait_rsp("ir_idcode2");
    scan("dr_idcode2", 1'b0, 32, 64'h0, 1'b1, 64'hBADC0FFE, 1'b0, 37);
    wait_rsp("dr_idcode2");

    repeat (5) @(posedge tck);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 Parameter MAX_LEN, default 64: maximum scan length in bits.
REQ-002 Parameter LEN_W, default $clog2(MAX_LEN+1): width of the length field.
REQ-003 Parameter RST_TMS_CNT, default 5: number of consecutive TMS=1 cycles in the reset sequence.
REQ-004 tck  in  1  single clock, free-running; internal state on rising edge, TAP pins launched on falling edge.
REQ-005 trstn  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_i  in  1 / cmd_ready_o  out  1: scan-command handshake, transfer when both high at rising tck.
REQ-007 cmd_ir_i  in  1: 1 = IR scan, 0 = DR scan.
REQ-008 cmd_len_i  in  LEN_W: scan length in bits.
REQ-009 cmd_data_i  in  MAX_LEN: TDI payload, LSB shifted first.
REQ-010 rsp_valid_o  out  1 / rsp_ready_i  in  1: result handshake.
REQ-011 rsp_data_o  out  MAX_LEN: captured TDO bits, bit i = i-th bit shifted out; bits >= len are zero.
REQ-012 rsp_err_o  out  1: command had cmd_len_i == 0.
REQ-013 tms_o, tdi_o  out  1: TAP pins to target, changed only on falling tck.
REQ-014 tdo_i  in  1: TAP pin from target, sampled on rising tck.
REQ-015 busy_o  out  1: high from reset until the FSM is back in RUN_TEST_IDLE with no scan in flight.

Function
REQ-016 The block SHALL track the target TAP state in a tap_ctrl_fsm_t register, updated at each rising tck from the tms_o value currently driven.
REQ-017 tms_o/tdi_o SHALL be computed from the rising-edge state and registered on falling tck, so they are stable across every target sampling edge.
REQ-018 After reset: RST_TMS_CNT cycles TMS=1 (TEST_LOGIC_RESET), then one cycle TMS=0 into RUN_TEST_IDLE; cmd_ready_o low throughout.
REQ-019 cmd_ready_o = (state == RUN_TEST_IDLE) && !rsp_valid_o && !busy; it is derived from registers only.
REQ-020 In RUN_TEST_IDLE with no accepted command, tms_o SHALL be 0.
REQ-021 DR scan TMS sequence after accept: 1,0,0 (SELECT_DR, CAPTURE_DR, SHIFT_DR); IR scan: 1,1,0,0 (SELECT_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR).
REQ-022 In SHIFT: exactly len rising edges.
- TMS=0 on the first len-1 edges, TMS=1 on the last (to EXIT1).
- tdi_o = cmd_data[i] on edge i.
- tdo_i captured into rsp_data[i] on the same edge.
REQ-023 After EXIT1: TMS=1 (UPDATE), then TMS=0 (RUN_TEST_IDLE).
REQ-024 rsp_valid_o rises on the edge entering RUN_TEST_IDLE.
- Accept-to-rsp_valid latency: DR = len+5 edges; IR = len+6 edges.
REQ-025 len == 1: single SHIFT edge carrying TMS=1.
REQ-026 len > MAX_LEN SHALL saturate to MAX_LEN.
REQ-027 len == 0: no TAP movement (TMS stays 0); rsp_valid_o next edge with rsp_data_o = 0 and rsp_err_o = 1.
REQ-028 rsp_valid_o/rsp_data_o/rsp_err_o SHALL hold until rsp_ready_i.
- cmd_valid_i in the same cycle as rsp_ready_i is accepted no earlier than the following edge.
REQ-029 cmd_data_i/cmd_ir_i/cmd_len_i SHALL be latched at accept; later input changes are ignored.

Reset
REQ-030 On trstn low, asynchronously: TAP model = TEST_LOGIC_RESET, tms_o = 1, tdi_o = 0, cmd_ready_o = 0, rsp_valid_o = 0, rsp_data_o = 0, rsp_err_o = 0, busy_o = 1, all counters 0.
REQ-031 Reset mid-scan SHALL abort the scan with no response, then rerun the REQ-018 sequence.

Structure
REQ-032 The following SHALL reside in jtag_pkg:
- tap_ctrl_fsm_t (existing type).
- JTAG_HOST_MAX_LEN constant.
- IR opcode constants shared with the target.
REQ-033 Sub-module jtag_tap_model SHALL provide the combinational IEEE 1149.1 next-state function (state, tms -> next state), reusable by the target TAP.

Verification
REQ-034 Release reset -> tms_o = 1 for exactly 5 edges, then 0; cmd_ready_o rises on the 7th edge; busy_o falls.
REQ-035 Against data_registers with IDCODE_VAL = 0xBADC0FFE:
- IR scan loads the IDCODE opcode.
- DR scan len = 32 -> rsp_data_o = 0xBADC0FFE, rsp_err_o = 0, latency 37 edges.
REQ-036 BYPASS loaded, DR scan len 8 with data 0xA5 -> rsp_data_o = {0xA5[6:0],0}, i.e. 0x4A.
REQ-037 cmd_len_i = 0 -> rsp_err_o = 1, rsp_data_o = 0, tms_o never 1.
REQ-038 rsp_ready_i held low 20 cycles -> response stable, cmd_ready_o = 0, tms_o = 0 throughout.
REQ-039 trstn pulsed at SHIFT edge 10 of a 32-bit scan -> no response; reset sequence reruns; the next scan completes correctly.
